// File: rtl/fe_redirect_ctrl.sv
// fe_redirect_ctrl: PC owner and FE latch; takes AGEX redirects, squashes wrong-path work, honours DE stall.
// Optional FE_PERF_CNT_EN adds redirect and stall-cycle performance counters.
module fe_redirect_ctrl #(
  parameter logic [31:0] STARTPC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        stall_de,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic        fe_valid,
  output logic [31:0] fe_inst,
  output logic [31:0] fe_pc,
  output logic [31:0] fe_pcplus,
  output logic [31:0] fe_inst_count,
  output logic        squash_de,
  output logic        misalign_err
`ifdef FE_PERF_CNT_EN
  ,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_stall_cycles
`endif
);
  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
  state_t      state;
  logic [31:0] pc, cnt;
  logic        fetch;
  // a FLUSH cycle always loads because the latch is empty, even under stall
  assign fetch     = !redirect_valid && (!stall_de || state == FLUSH);
  assign imem_addr = pc;
  assign squash_de = redirect_valid;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= RUN;
      pc            <= STARTPC;
      cnt           <= '0;
      fe_valid      <= 1'b0;
      fe_inst       <= '0;
      fe_pc         <= '0;
      fe_pcplus     <= '0;
      fe_inst_count <= '0;
      misalign_err  <= 1'b0;
    end else begin
      if (redirect_valid) begin
        state    <= FLUSH;
        pc       <= {redirect_target[31:2], 2'b00};
        fe_valid <= 1'b0;
      end else begin
        state <= stall_de ? STALL : RUN;
        if (fetch) begin
          fe_valid      <= 1'b1;
          fe_inst       <= imem_rdata;
          fe_pc         <= pc;
          fe_pcplus     <= pc + 32'd4;
          fe_inst_count <= cnt;
          pc            <= pc + 32'd4;
          cnt           <= cnt + 32'd1;
        end
      end
      if (redirect_valid && |redirect_target[1:0]) misalign_err <= 1'b1;
    end
  end
`ifdef FE_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_redirects    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (redirect_valid) perf_redirects <= perf_redirects + 32'd1;
      if (stall_de && !redirect_valid) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fe_redirect_ctrl.sv
// tb_fe_redirect_ctrl: directed checks of fetch, stall, redirect, misalign, wrap and async reset.
module tb_fe_redirect_ctrl;
  localparam logic [31:0] K = 32'h1357_9BDF;
  logic clk = 0, reset = 1;
  logic redirect_valid = 0, stall_de = 0;
  logic [31:0] redirect_target = 0;
  logic [31:0] imem_rdata, imem_addr, fe_inst, fe_pc, fe_pcplus, fe_inst_count;
  logic fe_valid, squash_de, misalign_err;
  logic w_rv = 0, w_st = 0;
  logic [31:0] w_tgt = 0;
  logic [31:0] w_rdata, w_addr, w_inst, w_pc, w_pcplus, w_cnt;
  logic w_valid, w_squash, w_mis;
`ifdef FE_PERF_CNT_EN
  logic [31:0] perf_redirects, perf_stall_cycles, w_pr, w_ps;
`endif
  int vecs = 0, fails = 0;

  assign imem_rdata = imem_addr ^ K;
  assign w_rdata    = w_addr ^ K;

  fe_redirect_ctrl #(.STARTPC(32'h200)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .stall_de(stall_de), .imem_rdata(imem_rdata), .imem_addr(imem_addr), .fe_valid(fe_valid),
    .fe_inst(fe_inst), .fe_pc(fe_pc), .fe_pcplus(fe_pcplus), .fe_inst_count(fe_inst_count),
    .squash_de(squash_de), .misalign_err(misalign_err)
`ifdef FE_PERF_CNT_EN
    , .perf_redirects(perf_redirects), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  fe_redirect_ctrl #(.STARTPC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset), .redirect_valid(w_rv), .redirect_target(w_tgt),
    .stall_de(w_st), .imem_rdata(w_rdata), .imem_addr(w_addr), .fe_valid(w_valid),
    .fe_inst(w_inst), .fe_pc(w_pc), .fe_pcplus(w_pcplus), .fe_inst_count(w_cnt),
    .squash_de(w_squash), .misalign_err(w_mis)
`ifdef FE_PERF_CNT_EN
    , .perf_redirects(w_pr), .perf_stall_cycles(w_ps)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fe(input string nm, input logic v, input logic [31:0] pc, input logic [31:0] cnt);
    vecs++;
    if ({fe_valid, fe_pc, fe_inst_count} !== {v, pc, cnt}) begin
      fails++;
      $display("FAIL %s: got v=%b pc=%h cnt=%0d, want v=%b pc=%h cnt=%0d", nm, fe_valid, fe_pc, fe_inst_count, v, pc, cnt);
    end
  endtask

  task automatic test_reset();
    step();
    vecs++;
    if ({imem_addr, fe_valid, fe_pc, fe_inst, fe_inst_count, squash_de, misalign_err} !== {32'h200, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset: got addr=%h v=%b pc=%h inst=%h cnt=%h sq=%b mis=%b, want addr=200 all else 0", imem_addr, fe_valid, fe_pc, fe_inst, fe_inst_count, squash_de, misalign_err);
    end
    reset = 0;
  endtask

  task automatic test_sequential();
    step();
    chk_fe("seq0", 1, 32'h200, 0);
    vecs++;
    if ({fe_inst, fe_pcplus, imem_addr} !== {32'h200 ^ K, 32'h204, 32'h204}) begin
      fails++;
      $display("FAIL seq0_data: got inst=%h pcplus=%h addr=%h, want inst=%h pcplus=204 addr=204", fe_inst, fe_pcplus, imem_addr, 32'h200 ^ K);
    end
    step();
    chk_fe("seq1", 1, 32'h204, 1);
  endtask

  task automatic test_stall();
    stall_de = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_fe($sformatf("stall%0d", i), 1, 32'h204, 1);
      vecs++;
      if (fe_inst !== (32'h204 ^ K)) begin
        fails++;
        $display("FAIL stall_inst%0d: got %h want %h", i, fe_inst, 32'h204 ^ K);
      end
    end
    stall_de = 0;
    step();
    chk_fe("stall_exit", 1, 32'h208, 2);
    vecs++;
    if (fe_pcplus !== 32'h20C) begin
      fails++;
      $display("FAIL stall_exit_pcplus: got %h want 20c", fe_pcplus);
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1;
    redirect_target = 32'h300;
    #1;
    vecs++;
    if (squash_de !== 1'b1) begin
      fails++;
      $display("FAIL redir_squash: got %b want 1", squash_de);
    end
    step();
    redirect_valid = 0;
    #1;
    vecs++;
    if ({fe_valid, imem_addr, squash_de} !== {1'b0, 32'h300, 1'b0}) begin
      fails++;
      $display("FAIL redir_bubble: got v=%b addr=%h sq=%b, want v=0 addr=300 sq=0", fe_valid, imem_addr, squash_de);
    end
    step();
    chk_fe("redir_target", 1, 32'h300, 3);
  endtask

  task automatic test_redirect_stall();
    redirect_valid = 1;
    redirect_target = 32'h400;
    stall_de = 1;
    step();
    redirect_valid = 0;
    vecs++;
    if ({fe_valid, imem_addr} !== {1'b0, 32'h400}) begin
      fails++;
      $display("FAIL rs_bubble: got v=%b addr=%h, want v=0 addr=400", fe_valid, imem_addr);
    end
    step();
    chk_fe("rs_load", 1, 32'h400, 4);
    step();
    chk_fe("rs_hold", 1, 32'h400, 4);
    stall_de = 0;
    step();
    chk_fe("rs_release", 1, 32'h404, 5);
  endtask

  task automatic test_misalign();
    redirect_valid = 1;
    redirect_target = 32'h302;
    step();
    redirect_valid = 0;
    vecs++;
    if ({misalign_err, imem_addr, fe_valid} !== {1'b1, 32'h300, 1'b0}) begin
      fails++;
      $display("FAIL misalign: got mis=%b addr=%h v=%b, want mis=1 addr=300 v=0", misalign_err, imem_addr, fe_valid);
    end
    step();
    chk_fe("mis_target", 1, 32'h300, 6);
    step();
    chk_fe("mis_next", 1, 32'h304, 7);
    vecs++;
    if (misalign_err !== 1'b1) begin
      fails++;
      $display("FAIL mis_sticky: got %b want 1", misalign_err);
    end
  endtask

  task automatic test_back_to_back();
    redirect_valid = 1;
    redirect_target = 32'h500;
    step();
    redirect_target = 32'h600;
    step();
    redirect_valid = 0;
    vecs++;
    if ({fe_valid, imem_addr} !== {1'b0, 32'h600}) begin
      fails++;
      $display("FAIL b2b_bubble: got v=%b addr=%h, want v=0 addr=600", fe_valid, imem_addr);
    end
    step();
    chk_fe("b2b_target", 1, 32'h600, 8);
  endtask

  task automatic test_async_reset();
    stall_de = 1;
    step();
    #2;
    reset = 1;
    #1;
    vecs++;
    if ({fe_valid, fe_pc, fe_inst_count, imem_addr, misalign_err} !== {1'b0, 32'h0, 32'h0, 32'h200, 1'b0}) begin
      fails++;
      $display("FAIL async_reset: got v=%b pc=%h cnt=%h addr=%h mis=%b, want 0/0/0/200/0", fe_valid, fe_pc, fe_inst_count, imem_addr, misalign_err);
    end
    stall_de = 0;
    step();
    reset = 0;
  endtask

  task automatic test_wrap();
    step();
    vecs++;
    if ({w_valid, w_pc, w_pcplus, w_cnt} !== {1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0}) begin
      fails++;
      $display("FAIL wrap0: got v=%b pc=%h pcplus=%h cnt=%h, want 1/fffffffc/0/0", w_valid, w_pc, w_pcplus, w_cnt);
    end
    chk_fe("post_reset", 1, 32'h200, 0);
    step();
    vecs++;
    if ({w_pc, w_pcplus, w_cnt, w_inst} !== {32'h0, 32'h4, 32'h1, K}) begin
      fails++;
      $display("FAIL wrap1: got pc=%h pcplus=%h cnt=%h inst=%h, want 0/4/1/%h", w_pc, w_pcplus, w_cnt, w_inst, K);
    end
  endtask

`ifdef FE_PERF_CNT_EN
  task automatic test_perf();
    reset = 1;
    step();
    reset = 0;
    stall_de = 1;
    step();
    redirect_valid = 1;
    redirect_target = 32'h700;
    step();
    redirect_valid = 0;
    for (int i = 0; i < 3; i++) step();
    stall_de = 0;
    redirect_valid = 1;
    step();
    redirect_valid = 0;
    step();
    vecs++;
    if ({perf_redirects, perf_stall_cycles} !== {32'd2, 32'd4}) begin
      fails++;
      $display("FAIL perf: got red=%0d stall=%0d, want 2/4", perf_redirects, perf_stall_cycles);
    end
    #2;
    reset = 1;
    #1;
    vecs++;
    if ({perf_redirects, perf_stall_cycles} !== 64'h0) begin
      fails++;
      $display("FAIL perf_reset: got red=%0d stall=%0d, want 0/0", perf_redirects, perf_stall_cycles);
    end
    step();
    reset = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_misalign();
    test_back_to_back();
    test_async_reset();
    test_wrap();
`ifdef FE_PERF_CNT_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
